// File: rtl/dma_xfer_engine_if.sv
// ----------------------------------------------------------------------------
// dma_xfer_engine_if
//   Bundles the descriptor handshake, bus arbitration and data-bus signals
//   of the DMA transfer engine.
//   master : the DMA engine (drives address/strobes, samples data_in/GPIO)
//   slave  : the processor / bus-mux side (issues descriptors, grants bus)
// Signals:
//   instr/instr_valid/instr_ready : 26-bit descriptor handshake
//   bus_req/grant/busybus         : bus arbitration and mux select
//   address/data_in/data_out/data_oe : shared bus
//   memwrite/IOWrite1/IOWrite2    : write strobes per target window
//   IOAck1/IOAck2, GPIO1/GPIO2    : IO source read handshake
//   remaining/done/err            : progress and status
// ----------------------------------------------------------------------------
interface dma_xfer_engine_if #(
  parameter int DATA_W = 32
);
  logic [25:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              bus_req;
  logic              grant;
  logic              busybus;
  logic [7:0]        address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              memwrite;
  logic              IOWrite1;
  logic              IOWrite2;
  logic              IOAck1;
  logic              IOAck2;
  logic              GPIO1;
  logic              GPIO2;
  logic [5:0]        remaining;
  logic              done;
  logic              err;

  modport master (
    input  instr, instr_valid, grant, data_in, GPIO1, GPIO2,
    output instr_ready, bus_req, busybus, address, data_out, data_oe,
           memwrite, IOWrite1, IOWrite2, IOAck1, IOAck2,
           remaining, done, err
  );

  modport slave (
    output instr, instr_valid, grant, data_in, GPIO1, GPIO2,
    input  instr_ready, bus_req, busybus, address, data_out, data_oe,
           memwrite, IOWrite1, IOWrite2, IOAck1, IOAck2,
           remaining, done, err
  );
endinterface

// File: rtl/dma_xfer_engine.sv
// ----------------------------------------------------------------------------
// dma_xfer_engine
//   Bus-master DMA engine. Accepts one descriptor at a time, requests the
//   shared bus, then moves `count` words, one READ + WRITE pair per beat,
//   from a source address range to a destination address range. Source and
//   destination windows (memory / IO1 / IO2) are re-decoded on every beat.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : dma_xfer_engine_if master modport (descriptor, bus, status)
// Descriptor: [25:24] op, [23:22] mode, [21:14] src, [13:6] dest, [5:0] count
// ----------------------------------------------------------------------------
module dma_xfer_engine #(
  parameter int DATA_W  = 32,
  parameter int MEM_TOP = 191,
  parameter int IO1_TOP = 223
) (
  input logic               clock,
  input logic               reset_n,
  dma_xfer_engine_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_e;
  typedef enum logic [1:0] {WIN_MEM, WIN_IO1, WIN_IO2} win_e;

  localparam logic [7:0] MEM_TOP_A = 8'(MEM_TOP);
  localparam logic [7:0] IO1_TOP_A = 8'(IO1_TOP);

  function automatic win_e decode_win(input logic [7:0] a);
    if (a <= MEM_TOP_A)      return WIN_MEM;
    else if (a <= IO1_TOP_A) return WIN_IO1;
    else                     return WIN_IO2;
  endfunction

  // Descriptor fields
  logic [1:0] d_op, d_mode;
  logic [7:0] d_src, d_dest;
  logic [5:0] d_count;
  assign {d_op, d_mode, d_src, d_dest, d_count} = bus.instr;

  state_e            state_q, state_d;
  logic [7:0]        src_q, src_d;
  logic [7:0]        dest_q, dest_d;
  logic [5:0]        remaining_q, remaining_d;
  logic              inc_dest_q, inc_dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  win_e src_win, dest_win;
  logic src_ready;

  assign src_win  = decode_win(src_q);
  assign dest_win = decode_win(dest_q);

  // Memory is always ready; IO sources are ready when their GPIO is high.
  always_comb begin
    case (src_win)
      WIN_IO1: src_ready = bus.GPIO1;
      WIN_IO2: src_ready = bus.GPIO2;
      default: src_ready = 1'b1;
    endcase
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dest_d      = dest_q;
    remaining_d = remaining_q;
    inc_dest_d  = inc_dest_q;
    data_d      = data_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ops 1x belong to the processor: consumed here with no effect.
        if (bus.instr_valid && !d_op[1]) begin
          if ((d_mode == 2'b01 || d_mode == 2'b10) && d_count != 6'd0) begin
            src_d       = d_src;
            dest_d      = d_dest;
            remaining_d = d_count;
            inc_dest_d  = (d_op == 2'b00);
            state_d     = S_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.grant) state_d = S_READ;
      end
      S_READ: begin
        if (src_ready) begin
          data_d  = bus.data_in;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        remaining_d = remaining_q - 6'd1;
        src_d       = src_q + 8'd1;            // 8-bit wrap: 255 -> 0
        if (inc_dest_q) dest_d = dest_q + 8'd1;
        // A beat always completes; a lost grant only stops the next beat.
        if (remaining_q == 6'd1) state_d = S_DONE;
        else if (!bus.grant)     state_d = S_REQ;
        else                     state_d = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  // NOTE: the data register is a single word, so it is reset along with the
  // control state; an abandoned transfer leaves nothing stale on data_out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dest_q      <= '0;
      remaining_q <= '0;
      inc_dest_q  <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dest_q      <= dest_d;
      remaining_q <= remaining_d;
      inc_dest_q  <= inc_dest_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Outputs decoded from the registered state. The request is held while
  // the engine owns the bus so the arbiter does not reclaim it mid-transfer.
  always_comb begin
    bus.instr_ready = (state_q == S_IDLE);
    bus.bus_req     = (state_q == S_REQ) || (state_q == S_READ) || (state_q == S_WRITE);
    bus.busybus     = (state_q == S_READ) || (state_q == S_WRITE);
    bus.address     = 8'd0;
    bus.data_out    = data_q;
    bus.data_oe     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.IOWrite1    = 1'b0;
    bus.IOWrite2    = 1'b0;
    bus.IOAck1      = 1'b0;
    bus.IOAck2      = 1'b0;
    bus.remaining   = remaining_q;
    bus.done        = (state_q == S_DONE);
    bus.err         = err_q;

    case (state_q)
      S_READ: begin
        bus.address = src_q;
        // Ack only on the cycle the word is actually taken.
        if (src_ready) begin
          bus.IOAck1 = (src_win == WIN_IO1);
          bus.IOAck2 = (src_win == WIN_IO2);
        end
      end
      S_WRITE: begin
        bus.address  = dest_q;
        bus.data_oe  = 1'b1;
        bus.memwrite = (dest_win == WIN_MEM);
        bus.IOWrite1 = (dest_win == WIN_IO1);
        bus.IOWrite2 = (dest_win == WIN_IO2);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// ----------------------------------------------------------------------------
// tb_dma_xfer_engine
//   Directed bench for dma_xfer_engine: memory->IO1 burst, IO2->memory with
//   GPIO wait, address wrap, grant drop, rejected/processor-only descriptors,
//   and asynchronous reset mid-burst. Inputs are driven 1 time unit after the
//   rising edge, outputs checked 1 unit later.
// ----------------------------------------------------------------------------
module tb_dma_xfer_engine;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;
  int   writes;
  bit   seen_done;

  dma_xfer_engine_if #(.DATA_W(32)) b ();

  dma_xfer_engine #(
    .DATA_W (32),
    .MEM_TOP(191),
    .IO1_TOP(223)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [25:0] mk(input logic [1:0] op, input logic [1:0] mode,
                                     input logic [7:0] src, input logic [7:0] dest,
                                     input logic [5:0] cnt);
    return {op, mode, src, dest, cnt};
  endfunction

  initial begin
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    b.instr       = '0;
    b.instr_valid = 1'b0;
    b.grant       = 1'b0;
    b.data_in     = '0;
    b.GPIO1       = 1'b0;
    b.GPIO2       = 1'b0;

    // ---------------- reset state ----------------
    #3;
    check("rst_ready",  b.instr_ready, 1);
    check("rst_req",    b.bus_req,     0);
    check("rst_busy",   b.busybus,     0);
    check("rst_addr",   b.address,     0);
    check("rst_rem",    b.remaining,   0);
    check("rst_dout",   b.data_out,    0);
    check("rst_done",   b.done,        0);
    check("rst_err",    b.err,         0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // ---------------- T1: mem -> IO1, op 00, grant high ----------------
    b.instr = mk(2'd0, 2'd1, 8'd10, 8'd200, 6'd3);
    b.instr_valid = 1'b1; b.grant = 1'b1; b.GPIO1 = 1'b1;
    #1;
    check("t1_ready", b.instr_ready, 1);
    step(); b.instr_valid = 1'b0; #1;            // cycle 1: REQ
    check("t1_req",      b.bus_req,     1);
    check("t1_req_busy", b.busybus,     0);
    check("t1_req_rdy",  b.instr_ready, 0);
    check("t1_req_rem",  b.remaining,   3);
    for (int k = 0; k < 3; k++) begin
      step(); b.data_in = 32'hA000_0000 + k; #1; // READ
      check("t1_rd_addr", b.address, 10 + k);
      check("t1_rd_busy", b.busybus, 1);
      check("t1_rd_oe",   b.data_oe, 0);
      step(); #1;                                // WRITE
      check("t1_wr_addr", b.address,  200 + k);
      check("t1_wr_io1",  b.IOWrite1, 1);
      check("t1_wr_mem",  b.memwrite, 0);
      check("t1_wr_oe",   b.data_oe,  1);
      check("t1_wr_data", b.data_out, 32'hA000_0000 + k);
      check("t1_wr_rem",  b.remaining, 3 - k);
    end
    step(); #1;                                  // cycle 8: DONE
    check("t1_done",      b.done,      1);
    check("t1_done_rem",  b.remaining, 0);
    check("t1_done_busy", b.busybus,   0);
    check("t1_done_err",  b.err,       0);
    step(); #1;
    check("t1_idle_done", b.done,        0);
    check("t1_idle_rdy",  b.instr_ready, 1);
    b.GPIO1 = 1'b0;

    // ---------------- T2: IO2 -> mem, op 01, GPIO2 wait ----------------
    b.instr = mk(2'd1, 2'd2, 8'd224, 8'd5, 6'd2);
    b.instr_valid = 1'b1; b.GPIO2 = 1'b0;
    step(); b.instr_valid = 1'b0; #1;            // REQ
    check("t2_req", b.bus_req, 1);
    for (int w = 0; w < 3; w++) begin
      step(); #1;                                // READ waiting
      check("t2_wait_addr", b.address, 224);
      check("t2_wait_ack",  b.IOAck2,  0);
      check("t2_wait_oe",   b.data_oe, 0);
    end
    step(); b.GPIO2 = 1'b1; b.data_in = 32'h1234_5678; #1;
    check("t2_rd0_ack", b.IOAck2, 1);
    step(); #1;
    check("t2_wr0_addr", b.address,  5);
    check("t2_wr0_mem",  b.memwrite, 1);
    check("t2_wr0_io2",  b.IOWrite2, 0);
    check("t2_wr0_data", b.data_out, 32'h1234_5678);
    step(); b.data_in = 32'h0BAD_F00D; #1;
    check("t2_rd1_addr", b.address, 225);
    check("t2_rd1_ack",  b.IOAck2,  1);
    step(); #1;
    check("t2_wr1_addr", b.address,  5);
    check("t2_wr1_mem",  b.memwrite, 1);
    check("t2_wr1_data", b.data_out, 32'h0BAD_F00D);
    step(); #1;
    check("t2_done", b.done, 1);
    step(); b.GPIO2 = 1'b0; #1;

    // ---------------- T3: source address wrap ----------------
    b.instr = mk(2'd0, 2'd1, 8'd254, 8'd100, 6'd3);
    b.instr_valid = 1'b1; b.GPIO2 = 1'b1;
    step(); b.instr_valid = 1'b0; #1;            // REQ
    step(); #1;
    check("t3_rd0_addr", b.address, 254);
    check("t3_rd0_ack",  b.IOAck2,  1);
    step(); #1;
    check("t3_wr0_addr", b.address, 100);
    step(); #1;
    check("t3_rd1_addr", b.address, 255);
    check("t3_rd1_ack",  b.IOAck2,  1);
    step(); #1;
    check("t3_wr1_addr", b.address, 101);
    step(); #1;
    check("t3_rd2_addr", b.address, 0);
    check("t3_rd2_busy", b.busybus, 1);
    check("t3_rd2_ack1", b.IOAck1,  0);
    check("t3_rd2_ack2", b.IOAck2,  0);
    step(); #1;
    check("t3_wr2_addr", b.address,  102);
    check("t3_wr2_mem",  b.memwrite, 1);
    step(); #1;
    check("t3_done", b.done, 1);
    step(); b.GPIO2 = 1'b0; #1;

    // ---------------- T4: grant drop during second WRITE ----------------
    b.instr = mk(2'd0, 2'd1, 8'd20, 8'd40, 6'd4);
    b.instr_valid = 1'b1; b.grant = 1'b1;
    step(); b.instr_valid = 1'b0; #1;            // cycle 1 REQ
    step(); #1;                                  // cycle 2 READ
    step(); #1;                                  // cycle 3 WRITE
    check("t4_wr0_mem", b.memwrite, 1);
    step(); #1;                                  // cycle 4 READ
    step(); b.grant = 1'b0; #1;                  // cycle 5 WRITE, grant lost
    check("t4_wr1_addr", b.address,  41);
    check("t4_wr1_mem",  b.memwrite, 1);
    step(); #1;                                  // cycle 6 REQ
    check("t4_rereq_busy", b.busybus, 0);
    check("t4_rereq_req",  b.bus_req, 1);
    check("t4_rereq_wr",   b.memwrite, 0);
    step(); b.grant = 1'b1; #1;                  // cycle 7 still REQ
    check("t4_hold_busy", b.busybus, 0);
    check("t4_hold_req",  b.bus_req, 1);
    writes    = 2;
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      step(); #1;
      if (b.memwrite) writes++;
      if (b.done)     seen_done = 1'b1;
    end
    check("t4_done_seen", seen_done, 1);
    check("t4_writes",    writes,    4);
    step(); #1;

    // ---------------- T5: rejects and processor-only op ----------------
    b.instr = mk(2'd0, 2'd0, 8'd1, 8'd2, 6'd3);   // invalid mode
    b.instr_valid = 1'b1;
    step(); b.instr_valid = 1'b0; #1;
    check("t5_mode_err",  b.err,         1);
    check("t5_mode_req",  b.bus_req,     0);
    check("t5_mode_done", b.done,        0);
    check("t5_mode_rdy",  b.instr_ready, 1);
    step(); #1;
    check("t5_mode_err_pulse", b.err,     0);
    check("t5_mode_req2",      b.bus_req, 0);

    b.instr = mk(2'd1, 2'd1, 8'd1, 8'd2, 6'd0);   // count 0
    b.instr_valid = 1'b1;
    step(); b.instr_valid = 1'b0; #1;
    check("t5_cnt_err", b.err,     1);
    check("t5_cnt_req", b.bus_req, 0);
    step(); #1;
    check("t5_cnt_err_pulse", b.err, 0);

    b.instr = mk(2'd2, 2'd1, 8'd1, 8'd2, 6'd3);   // processor op
    b.instr_valid = 1'b1;
    step(); b.instr_valid = 1'b0; #1;
    check("t5_op2_err", b.err,         0);
    check("t5_op2_req", b.bus_req,     0);
    check("t5_op2_rdy", b.instr_ready, 1);
    step(); #1;
    check("t5_op2_req2",  b.bus_req, 0);
    check("t5_op2_done2", b.done,    0);

    // ---------------- T6: async reset in second beat ----------------
    b.instr = mk(2'd0, 2'd1, 8'd30, 8'd60, 6'd3);
    b.instr_valid = 1'b1; b.data_in = 32'hCAFE_0001;
    step(); b.instr_valid = 1'b0; #1;            // REQ
    step(); #1;                                  // READ
    step(); #1;                                  // WRITE
    step(); #1;                                  // second READ
    check("t6_pre_addr", b.address, 31);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", b.busybus,     0);
    check("t6_rst_req",  b.bus_req,     0);
    check("t6_rst_addr", b.address,     0);
    check("t6_rst_rem",  b.remaining,   0);
    check("t6_rst_rdy",  b.instr_ready, 1);
    check("t6_rst_dout", b.data_out,    0);
    check("t6_rst_done", b.done,        0);
    @(negedge clock);
    reset_n = 1'b1;
    step(); #1;
    check("t6_after_done", b.done, 0);
    b.instr = mk(2'd0, 2'd1, 8'd50, 8'd70, 6'd1);
    b.instr_valid = 1'b1; b.data_in = 32'h0000_BEEF;
    step(); b.instr_valid = 1'b0; #1;
    check("t6_new_req", b.bus_req, 1);
    step(); #1;
    check("t6_new_rd", b.address, 50);
    step(); #1;
    check("t6_new_wr_addr", b.address,  70);
    check("t6_new_wr_mem",  b.memwrite, 1);
    check("t6_new_wr_data", b.data_out, 32'h0000_BEEF);
    step(); #1;
    check("t6_new_done", b.done, 1);
    check("t6_new_rem",  b.remaining, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
